// File: rtl/bus_cycle_controller.sv
// 68k-style bus cycle controller: address decode, wait states,
// DTACK/VPA/BERR generation and DUART interrupt acknowledge.
module bus_cycle_controller #(
  parameter int ROM_WAIT     = 2,
  parameter int RAM_WAIT     = 0,
  parameter int IO_WAIT      = 3,
  parameter int BERR_TIMEOUT = 64,
  parameter int DUART_IPL    = 5
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       AS,
  input  logic       UDS,
  input  logic       LDS,
  input  logic [2:0] FC,
  input  logic [3:0] ADDR_H,
  input  logic [2:0] ADDR_L,
  input  logic       DUART_DTACK,
  output logic       DTACK,
  output logic       BERR,
  output logic       VPA,
  output logic       IACK_DUART
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_EXT,
    S_ACK,
    S_AVEC,
    S_BERR
  } state_t;

  localparam logic [7:0] ROM_W = 8'(ROM_WAIT);
  localparam logic [7:0] RAM_W = 8'(RAM_WAIT);
  localparam logic [7:0] IO_W  = 8'(IO_WAIT);
  localparam logic [7:0] TMO   = 8'(BERR_TIMEOUT);
  localparam logic [2:0] IPL   = 3'(DUART_IPL);

  state_t     state;
  logic [7:0] wait_cnt;
  logic [7:0] wd_cnt;
  logic       ack_en;

  logic       start;
  logic       is_iack;
  logic       is_rom;
  logic       is_ram;
  logic       is_duart;
  logic       is_io;
  logic [7:0] wd_next;
  logic       wd_hit;

  assign start = !AS && (!UDS || !LDS);

  always_comb begin
    is_iack  = 1'b0;
    is_rom   = 1'b0;
    is_ram   = 1'b0;
    is_duart = 1'b0;
    is_io    = 1'b0;
    if (FC == 3'b111 && ADDR_H == 4'hF)
      is_iack = 1'b1;
    else if (ADDR_H == 4'h0)
      is_rom = 1'b1;
    else if (ADDR_H >= 4'h8 && ADDR_H <= 4'hB)
      is_ram = 1'b1;
    else if (ADDR_H >= 4'hC && ADDR_H <= 4'hE)
      is_duart = 1'b1;
    else if (ADDR_H == 4'hF)
      is_io = 1'b1;
  end

  // Watchdog saturates at all-ones rather than wrapping
  assign wd_next = (wd_cnt == 8'hFF) ? wd_cnt : wd_cnt + 8'd1;
  assign wd_hit  = (wd_next >= TMO);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state      <= S_IDLE;
      wait_cnt   <= 8'd0;
      wd_cnt     <= 8'd0;
      ack_en     <= 1'b0;
      DTACK      <= 1'b1;
      BERR       <= 1'b1;
      VPA        <= 1'b1;
      IACK_DUART <= 1'b1;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            wd_cnt <= 8'd0;
            if (is_iack) begin
              if (ADDR_L == IPL) begin
                state      <= S_EXT;
                ack_en     <= 1'b1;
                IACK_DUART <= 1'b0;
              end else begin
                state <= S_AVEC;
              end
            end else if (is_rom) begin
              wait_cnt <= ROM_W;
              state    <= S_COUNT;
            end else if (is_ram) begin
              wait_cnt <= RAM_W;
              state    <= S_COUNT;
            end else if (is_io) begin
              wait_cnt <= IO_W;
              state    <= S_COUNT;
            end else begin
              // Unmapped cycles have no ack source; watchdog ends them
              ack_en <= is_duart;
              state  <= S_EXT;
            end
          end
        end
        S_COUNT: begin
          if (AS) begin
            state      <= S_IDLE;
            IACK_DUART <= 1'b1;
          end else begin
            wd_cnt <= wd_next;
            if (wait_cnt == 8'd0) begin
              state <= S_ACK;
              DTACK <= 1'b0;
            end else if (wd_hit) begin
              state <= S_BERR;
              BERR  <= 1'b0;
            end else begin
              wait_cnt <= wait_cnt - 8'd1;
            end
          end
        end
        S_EXT: begin
          if (AS) begin
            state      <= S_IDLE;
            IACK_DUART <= 1'b1;
          end else begin
            wd_cnt <= wd_next;
            if (ack_en && !DUART_DTACK) begin
              state <= S_ACK;
              DTACK <= 1'b0;
            end else if (wd_hit) begin
              state <= S_BERR;
              BERR  <= 1'b0;
            end
          end
        end
        S_ACK, S_BERR: begin
          if (AS) begin
            state      <= S_IDLE;
            DTACK      <= 1'b1;
            BERR       <= 1'b1;
            IACK_DUART <= 1'b1;
          end
        end
        S_AVEC: begin
          if (AS) begin
            state <= S_IDLE;
            VPA   <= 1'b1;
          end else begin
            VPA <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_cycle_controller.sv
// Directed bench for bus_cycle_controller with default parameters.
module tb_bus_cycle_controller;

  logic       CLK = 1'b0;
  logic       RST;
  logic       AS;
  logic       UDS;
  logic       LDS;
  logic [2:0] FC;
  logic [3:0] ADDR_H;
  logic [2:0] ADDR_L;
  logic       DUART_DTACK;
  logic       DTACK;
  logic       BERR;
  logic       VPA;
  logic       IACK_DUART;

  int total = 0;
  int bad   = 0;

  // {DTACK, BERR, VPA, IACK_DUART}
  localparam logic [3:0] IDLE_O = 4'b1111;
  localparam logic [3:0] ACK_O  = 4'b0111;
  localparam logic [3:0] BERR_O = 4'b1011;
  localparam logic [3:0] VPA_O  = 4'b1101;
  localparam logic [3:0] IACK_O = 4'b1110;
  localparam logic [3:0] IACK_A = 4'b0110;

  wire [3:0] outs = {DTACK, BERR, VPA, IACK_DUART};

  bus_cycle_controller dut (
    .CLK(CLK),
    .RST(RST),
    .AS(AS),
    .UDS(UDS),
    .LDS(LDS),
    .FC(FC),
    .ADDR_H(ADDR_H),
    .ADDR_L(ADDR_L),
    .DUART_DTACK(DUART_DTACK),
    .DTACK(DTACK),
    .BERR(BERR),
    .VPA(VPA),
    .IACK_DUART(IACK_DUART)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [3:0] got,
                     input logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %b exp %b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic run(input int n, input string tag,
                     input logic [3:0] exp);
    for (int i = 0; i < n; i++) begin
      tick();
      chk(tag, outs, exp);
    end
  endtask

  task automatic start_cyc(input logic [2:0] fc, input logic [3:0] ah,
                           input logic [2:0] al, input string tag,
                           input logic [3:0] exp);
    FC = fc;
    ADDR_H = ah;
    ADDR_L = al;
    AS = 1'b0;
    UDS = 1'b0;
    LDS = 1'b0;
    tick();
    chk(tag, outs, exp);
  endtask

  task automatic end_cyc(input string tag);
    AS = 1'b1;
    UDS = 1'b1;
    LDS = 1'b1;
    tick();
    chk(tag, outs, IDLE_O);
    tick();
  endtask

  initial begin
    RST = 1'b0;
    AS = 1'b1;
    UDS = 1'b1;
    LDS = 1'b1;
    FC = 3'b101;
    ADDR_H = 4'h0;
    ADDR_L = 3'd0;
    DUART_DTACK = 1'b1;
    run(2, "reset", IDLE_O);
    RST = 1'b1;
    run(1, "idle", IDLE_O);

    // RAM, zero wait states
    start_cyc(3'b101, 4'h8, 3'd0, "ram_e0", IDLE_O);
    run(1, "ram_e1", ACK_O);
    run(2, "ram_hold", ACK_O);
    end_cyc("ram_rel");

    // RAM via lower strobe only
    FC = 3'b101;
    ADDR_H = 4'hA;
    AS = 1'b0;
    LDS = 1'b0;
    tick();
    chk("lds_e0", outs, IDLE_O);
    run(1, "lds_e1", ACK_O);
    end_cyc("lds_rel");

    // ROM, two wait states
    start_cyc(3'b110, 4'h0, 3'd0, "rom_e0", IDLE_O);
    run(2, "rom_wait", IDLE_O);
    run(1, "rom_e3", ACK_O);
    end_cyc("rom_rel");

    // IO, three wait states
    start_cyc(3'b101, 4'hF, 3'd0, "io_e0", IDLE_O);
    run(3, "io_wait", IDLE_O);
    run(1, "io_e4", ACK_O);
    end_cyc("io_rel");

    // AS without data strobes never starts a cycle
    ADDR_H = 4'hF;
    AS = 1'b0;
    run(6, "no_strobe", IDLE_O);
    AS = 1'b1;
    tick();

    // DUART acknowledged at edge 5
    start_cyc(3'b101, 4'hC, 3'd1, "duart_e0", IDLE_O);
    run(4, "duart_wait", IDLE_O);
    DUART_DTACK = 1'b0;
    run(1, "duart_e5", ACK_O);
    DUART_DTACK = 1'b1;
    run(1, "duart_hold", ACK_O);
    end_cyc("duart_rel");

    // DUART never acknowledges
    start_cyc(3'b101, 4'hD, 3'd1, "dto_e0", IDLE_O);
    run(63, "dto_wait", IDLE_O);
    run(1, "dto_e64", BERR_O);
    run(2, "dto_hold", BERR_O);
    end_cyc("dto_rel");

    // Unmapped region
    start_cyc(3'b101, 4'h3, 3'd0, "unm_e0", IDLE_O);
    run(63, "unm_wait", IDLE_O);
    run(1, "unm_e64", BERR_O);
    end_cyc("unm_rel");

    // IACK at the DUART level
    start_cyc(3'b111, 4'hF, 3'd5, "iack5_e0", IACK_O);
    run(2, "iack5_wait", IACK_O);
    DUART_DTACK = 1'b0;
    run(1, "iack5_ack", IACK_A);
    DUART_DTACK = 1'b1;
    end_cyc("iack5_rel");

    // IACK at another level autovectors
    start_cyc(3'b111, 4'hF, 3'd2, "iack2_e0", IDLE_O);
    run(1, "iack2_e1", VPA_O);
    run(2, "iack2_hold", VPA_O);
    end_cyc("iack2_rel");

    // ROM cycle aborted by AS at edge 3
    start_cyc(3'b110, 4'h0, 3'd0, "abort_e0", IDLE_O);
    run(2, "abort_wait", IDLE_O);
    AS = 1'b1;
    UDS = 1'b1;
    LDS = 1'b1;
    run(4, "abort_idle", IDLE_O);

    // Aborted DUART IACK releases IACK_DUART
    start_cyc(3'b111, 4'hF, 3'd5, "iabort_e0", IACK_O);
    AS = 1'b1;
    UDS = 1'b1;
    LDS = 1'b1;
    run(2, "iabort_idle", IDLE_O);

    // Reset mid IO cycle, then restart with AS still low
    start_cyc(3'b101, 4'hF, 3'd0, "rst_e0", IDLE_O);
    run(1, "rst_e1", IDLE_O);
    RST = 1'b0;
    run(1, "rst_e2", IDLE_O);
    RST = 1'b1;
    run(1, "rst_restart", IDLE_O);
    run(3, "rst_wait", IDLE_O);
    run(1, "rst_e4", ACK_O);
    end_cyc("rst_rel");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_cycle_controller.md
BUS_CYCLE_CONTROLLER -- requirements
Module: bus_cycle_controller

Interface
REQ-001 Parameter ROM_WAIT, default 2: wait cycles before DTACK for the ROM region.
REQ-002 Parameter RAM_WAIT, default 0: wait cycles before DTACK for the RAM region.
REQ-003 Parameter IO_WAIT, default 3: wait cycles before DTACK for the LED/IO region.
REQ-004 Parameter BERR_TIMEOUT, default 64: watchdog limit in CLK cycles; legal range 1..255.
REQ-005 Parameter DUART_IPL, default 5: interrupt level served by the DUART vector.
REQ-006 The block SHALL have the following ports, with the clock and reset as already decided (reset RST, synchronous, active-low; clock CLK):
- CLK  in  1  CPU bus clock; all state changes on the rising edge
- RST  in  1  synchronous reset, active-low
- AS  in  1  address strobe, active-low
- UDS  in  1  upper data strobe, active-low
- LDS  in  1  lower data strobe, active-low
- FC  in  3  CPU function code
- ADDR_H  in  4  address bits 23:20
- ADDR_L  in  3  address bits 3:1 (IACK level)
- DUART_DTACK  in  1  DTACK from the DUART, active-low
- DTACK  out  1  data acknowledge to the CPU, active-low, registered
- BERR  out  1  bus error to the CPU, active-low, registered
- VPA  out  1  autovector request, active-low, registered
- IACK_DUART  out  1  DUART interrupt acknowledge, active-low, registered

Function
REQ-007 Cycle start: a cycle SHALL start on a rising edge in IDLE where AS=0 and (UDS=0 or LDS=0).
REQ-008 Classification SHALL be fixed at cycle start, with the first match winning:
- IACK: FC=111 and ADDR_H=F
- ROM: ADDR_H=0
- RAM: ADDR_H=8..B
- DUART: ADDR_H=C..E
- IO: ADDR_H=F
- otherwise UNMAPPED
REQ-009 The state machine SHALL have the states IDLE, COUNT, EXT, ACK, AVEC and BERR.
REQ-010 ROM, RAM and IO cycles SHALL load the 8-bit wait counter with the region wait value and go IDLE->COUNT.
REQ-011 In COUNT, if the counter is 0 the block SHALL go to ACK; otherwise it SHALL decrement the counter.
REQ-012 DTACK SHALL go low after the (N+1)th rising edge following the start edge, where N is the region wait value.
REQ-013 A DUART cycle SHALL go IDLE->EXT and SHALL go EXT->ACK on the edge where DUART_DTACK is sampled low.
REQ-014 An IACK cycle with ADDR_L=DUART_IPL SHALL drive IACK_DUART low from the start edge, go to EXT, and SHALL go EXT->ACK on the edge where DUART_DTACK is sampled low.
REQ-015 An IACK cycle at any other level SHALL go IDLE->AVEC with VPA low after the start edge; DTACK SHALL stay high.
REQ-016 An UNMAPPED cycle SHALL go IDLE->EXT with no acknowledge source, so that only the watchdog can terminate it.
REQ-017 Watchdog: an 8-bit counter SHALL clear at cycle start and increment each edge while in COUNT or EXT.
REQ-018 When the watchdog counter reaches BERR_TIMEOUT, the block SHALL go to BERR and drive BERR low.
REQ-019 If the watchdog timeout and an acknowledge occur on the same edge, the acknowledge SHALL win.
REQ-020 In ACK, AVEC and BERR the asserted output SHALL be held until AS is sampled high.
REQ-021 When AS is sampled high in ACK, AVEC or BERR, the block SHALL go to IDLE and deassert all outputs on that same edge.
REQ-022 If AS is sampled high in COUNT or EXT, the cycle is aborted: the block SHALL go to IDLE, release IACK_DUART, and never assert DTACK or BERR.
REQ-023 At most one of DTACK, BERR and VPA SHALL be low at any time.
REQ-024 A new cycle SHALL NOT start on the same edge that returns the block to IDLE.
REQ-025 The wait and watchdog counters SHALL saturate and SHALL never wrap.

Reset
REQ-026 When RST=0 at a rising edge, the block SHALL enter IDLE with both counters 0.
REQ-027 During reset, DTACK, BERR, VPA and IACK_DUART SHALL all be 1, including when reset occurs mid-cycle.
REQ-028 After RST returns to 1, a cycle already in progress with AS still low SHALL start as a new cycle on the next edge.

Verification
REQ-029 RAM read at 0x800000 with RAM_WAIT=0 -> DTACK low after edge 1, high on the edge after AS rises.
REQ-030 ROM read at 0x000000 -> DTACK low after edge 3 (ROM_WAIT=2); IO write at 0xF00000 -> DTACK low after edge 4.
REQ-031 DUART access at 0xC00001 with DUART_DTACK low at edge 5 -> DTACK low after edge 5; with DUART_DTACK never low -> BERR low after edge 64, DTACK stays high.
REQ-032 IACK cycle FC=111 at level 5 -> IACK_DUART low, DTACK follows DUART_DTACK; IACK at level 2 -> VPA low after edge 1, IACK_DUART stays high.
REQ-033 Cycle at 0x300000 -> BERR low after edge 64; AS high at edge 3 of a ROM cycle -> no DTACK, return to IDLE.
REQ-034 RST=0 at edge 2 of an IO cycle -> all outputs high after that edge; AS still low after RST=1 -> new cycle with DTACK low after edge 4 past release.
